seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the four-digit, common-anode seven-segment display on the stopwatch board. It accepts four BCD digits plus decimal points through a load strobe and holds them in a shadow register. It transfers them tear-free at frame boundaries and scans one digit per refresh slot. Each slot produces active-low anode and cathode patterns, with dead-time blanking and optional leading-zero suppression. It sits between the stopwatch counter logic and the board pins.

---
 rtl/seg7_scan_driver_pkg.sv | 32 +++
 rtl/seg7_scan_driver_bcd_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 96 +++++++++
 tb/tb_seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the four-digit common-anode seven-segment scan driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order, cathode[0] = segment a.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/seg7_scan_driver_bcd_decode.sv
// BCD to active-low seven-segment pattern; codes 10-15 decode to blank.
module seg7_bcd_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed display driver: shadow/active digit registers swapped at
// frame boundaries, per-slot dead-time blanking and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [15:0]      shadow_digits;
    logic [3:0]       shadow_dp;
    logic [15:0]      active_digits;
    logic [3:0]       active_dp;

    logic             slot_end;
    logic             frame_end;
    logic             lit;
    logic             suppress;
    logic [3:0]       lz;
    logic [3:0]       sel_digit;
    logic [6:0]       sel_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign lit       = enable && (cnt >= CNT_DEAD);
    assign sel_digit = active_digits[{idx, 2'b00} +: 4];

    // lz[k]: digit k and every digit above it are zero; digit 0 always shows
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (active_digits[15:12] == 4'd0);
        lz[2] = lz[3] && (active_digits[11:8] == 4'd0);
        lz[1] = lz[2] && (active_digits[7:4] == 4'd0);
    end

    assign suppress = blank_lz && lz[idx];

    seg7_bcd_decode u_decode (
        .bcd (sel_digit),
        .seg (sel_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            anode         <= 4'b1111;
            cathode       <= SEG_BLANK;
            dp            <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            // a load landing on the boundary edge goes straight to the display
            if (frame_end) begin
                active_digits <= load ? digits_in : shadow_digits;
                active_dp     <= load ? dp_in     : shadow_dp;
            end
            frame_done <= frame_end;
            anode      <= lit ? ~(4'b0001 << idx) : 4'b1111;
            cathode    <= (lit && !suppress) ? sel_seg : SEG_BLANK;
            dp         <= lit ? ~active_dp[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV=4, DEAD_CYCLES=1 (16-cycle frames).
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(.REFRESH_DIV(4), .DEAD_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpi;
        logic        lz;
        logic        en;
        logic [27:0] cat;   // {slot3, slot2, slot1, slot0} expected cathodes
        logic [3:0]  dpo;   // expected active-low dp per slot
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs [9];

    // One entry per cycle t=1..n after a frame boundary: t=4k+1 is dead time, others light slot k.
    task automatic push_frame(input logic en, input logic [27:0] cat, input logic [3:0] dpo, input int n);
        for (int t = 1; t <= n; t++) begin
            exp_t e;
            int   k;
            int   ph;
            k    = (t - 1) / 4;
            ph   = (t - 1) % 4;
            e.fd = (t == 16);
            if (ph == 0 || !en) begin
                e.anode   = 4'b1111;
                e.cathode = 7'b1111111;
                e.dp      = 1'b1;
            end else begin
                e.anode   = ~(4'b0001 << k);
                e.cathode = cat[k*7 +: 7];
                e.dp      = dpo[k];
            end
            sb.push_back(e);
        end
    endtask

    task automatic push_reset_entry();
        exp_t e;
        e.anode   = 4'b1111;
        e.cathode = 7'b1111111;
        e.dp      = 1'b1;
        e.fd      = 1'b0;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (anode !== mon_e.anode || cathode !== mon_e.cathode ||
                dp !== mon_e.dp || frame_done !== mon_e.fd) begin
                n_fail++;
                $display("FAIL scan @%0t: got anode=%b cathode=%b dp=%b fd=%b, want anode=%b cathode=%b dp=%b fd=%b",
                         $time, anode, cathode, dp, frame_done,
                         mon_e.anode, mon_e.cathode, mon_e.dp, mon_e.fd);
            end
        end
    end

    task automatic check_reset_outputs(input int cyc);
        n_tests++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got anode=%b cathode=%b dp=%b fd=%b, want 1111 1111111 1 0",
                     cyc, anode, cathode, dp, frame_done);
        end
    endtask

    task automatic load_vec(input vec_t v);
        blank_lz  = v.lz;
        enable    = v.en;
        digits_in = v.dig;
        dp_in     = v.dpi;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_frame_done: got no pulse in 40 cycles, want one within 16");
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        enable    = 1'b1;

        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 1'b1,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'h00A5, 4'b0000, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1111};
        vecs[4] = '{16'h00A5, 4'b0000, 1'b0, 1'b1,
                    {7'b1000000, 7'b1000000, 7'b1111111, 7'b0010010}, 4'b1111};
        vecs[5] = '{16'h8090, 4'b1001, 1'b1, 1'b1,
                    {7'b0000000, 7'b1000000, 7'b0010000, 7'b1000000}, 4'b0110};
        vecs[6] = '{16'h0006, 4'b1110, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000010}, 4'b0001};
        vecs[7] = '{16'h0006, 4'b1110, 1'b1, 1'b0,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000010}, 4'b0001};
        vecs[8] = '{16'h5678, 4'b0000, 1'b0, 1'b1,
                    {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111};

        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_reset_outputs(c);
        end

        // release: first lit anode on the 2nd edge, all digits zero
        rst_n = 1'b1;
        push_frame(1'b1, {4{7'b1000000}}, 4'b1111, 16);
        repeat (16) @(negedge clk);

        foreach (vecs[i]) begin
            repeat (2) @(negedge clk);
            load_vec(vecs[i]);
            wait_fd();
            push_frame(vecs[i].en, vecs[i].cat, vecs[i].dpo, 16);
            repeat (16) @(negedge clk);
        end

        // two mid-frame loads, then one coincident with the boundary edge
        push_frame(1'b1, vecs[8].cat, vecs[8].dpo, 16);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            case (t)
                3:  begin digits_in = 16'h1111; load = 1'b1; end
                4:  load = 1'b0;
                7:  begin digits_in = 16'h2222; load = 1'b1; end
                8:  load = 1'b0;
                15: begin digits_in = 16'h3333; load = 1'b1; end
                16: begin
                        load = 1'b0;
                        push_frame(1'b1, {4{7'b0110000}}, 4'b1111, 16);
                    end
                default: ;
            endcase
        end
        repeat (16) @(negedge clk);

        // reset at idx=2, cnt=2 with a pending shadow load of 9999
        push_frame(1'b1, {4{7'b0110000}}, 4'b1111, 10);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 5) begin
                digits_in = 16'h9999;
                load      = 1'b1;
            end
            if (t == 6) load = 1'b0;
        end
        rst_n = 1'b0;
        push_reset_entry();
        push_reset_entry();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(1'b1, {4{7'b1000000}}, 4'b1111, 16);
        push_frame(1'b1, {4{7'b1000000}}, 4'b1111, 16);
        repeat (32) @(negedge clk);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
